// File: rtl/run_control.sv
// run_control: run/step/breakpoint controller producing a registered clock-enable for a
// free-running datapath clock, with a synchronised/debounced front panel and a saturating cycle counter.
module run_control #(
  parameter int ADDR_WIDTH      = 16,
  parameter int BP_COUNT        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                           i_clk,
  input  logic                           i_resetn,
  input  logic                           i_btnStep,
  input  logic                           i_swInstrNCycle,
  input  logic                           i_swStepNRun,
  input  logic                           i_swEnableBp,
  input  logic [ADDR_WIDTH-1:0]          i_instrAddr,
  input  logic                           i_instrFinishedN,
  input  logic                           i_haltReq,
  input  logic [BP_COUNT*ADDR_WIDTH-1:0] i_bpAddr,
  input  logic [BP_COUNT-1:0]            i_bpValid,
  output logic                           o_clkEn,
  output logic                           o_halt,
  output logic [BP_COUNT-1:0]            o_bpHit,
  output logic                           o_bpHitN,
  output logic [CNT_WIDTH-1:0]           o_cycleCount
);

  localparam int SYNC_STAGES = 2;
  localparam int DB_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {PAUSED, STEP_CYC, STEP_INS, RUN, HALTED} state_t;

  // Synchroniser lanes: [3]=enableBp, [2]=stepNRun, [1]=instrNCycle, [0]=button
  logic [3:0]             syncQ1, syncQ2;
  logic [SYNC_STAGES-1:0] vldPipe;
  logic                   syncVld;
  logic                   btnS, instrNCycleS, stepNRunS, enableBpS;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      syncQ1  <= '0;
      syncQ2  <= '0;
      vldPipe <= '0;
    end else begin
      syncQ1  <= {i_swEnableBp, i_swStepNRun, i_swInstrNCycle, i_btnStep};
      syncQ2  <= syncQ1;
      vldPipe <= {vldPipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Switch levels are only trusted once the cleared synchroniser has refilled after reset.
  assign syncVld      = vldPipe[SYNC_STAGES-1];
  assign btnS         = syncQ2[0];
  assign instrNCycleS = syncQ2[1];
  assign stepNRunS    = syncQ2[2];
  assign enableBpS    = syncQ2[3];

  // Debounce: the level flips when the current sample plus the previous DEBOUNCE_CYCLES-1
  // samples all disagree with it; the step event fires in that same cycle.
  logic [DB_W-1:0] dbCnt;
  logic            dbLevel;
  logic            dbFlip, stepEvent;

  assign dbFlip    = (btnS != dbLevel) && (dbCnt == DB_LAST);
  assign stepEvent = dbFlip && btnS;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      dbCnt   <= '0;
      dbLevel <= 1'b0;
    end else if (btnS == dbLevel) begin
      dbCnt <= '0;
    end else if (dbFlip) begin
      dbCnt   <= '0;
      dbLevel <= btnS;
    end else begin
      dbCnt <= dbCnt + 1'b1;
    end
  end

  logic [BP_COUNT-1:0] bpMatch;

  for (genvar k = 0; k < BP_COUNT; k++) begin : gBp
    assign bpMatch[k] = i_bpValid[k] && enableBpS && !i_instrFinishedN &&
                        (i_bpAddr[k*ADDR_WIDTH +: ADDR_WIDTH] == i_instrAddr);
  end

  state_t              state;
  logic                clkEnQ, haltQ, leaveEn;
  logic [BP_COUNT-1:0] bpHitQ;

  always_comb begin
    leaveEn = 1'b0;
    case (state)
      STEP_CYC: leaveEn = 1'b1;
      STEP_INS: leaveEn = !i_instrFinishedN;
      RUN:      leaveEn = (|bpMatch) || stepNRunS;
      default:  leaveEn = 1'b0;
    endcase
  end

  // clkEnQ is set exactly when entering an enabled state, so it never depends on live inputs.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state  <= PAUSED;
      clkEnQ <= 1'b0;
      haltQ  <= 1'b0;
      bpHitQ <= '0;
    end else begin
      case (state)
        PAUSED: begin
          if (syncVld && !stepNRunS) begin
            state  <= RUN;
            clkEnQ <= 1'b1;
            bpHitQ <= '0;
          end else if (syncVld && stepEvent) begin
            state  <= instrNCycleS ? STEP_INS : STEP_CYC;
            clkEnQ <= 1'b1;
            bpHitQ <= '0;
          end
        end
        STEP_CYC, STEP_INS, RUN: begin
          bpHitQ <= bpHitQ | bpMatch;
          if (i_haltReq) begin
            state  <= HALTED;
            clkEnQ <= 1'b0;
            haltQ  <= 1'b1;
          end else if (leaveEn) begin
            state  <= PAUSED;
            clkEnQ <= 1'b0;
          end
        end
        HALTED: ;
        default: begin
          state  <= PAUSED;
          clkEnQ <= 1'b0;
        end
      endcase
    end
  end

  logic [CNT_WIDTH-1:0] cycleCnt;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      cycleCnt <= '0;
    else if (clkEnQ && (cycleCnt != '1))
      cycleCnt <= cycleCnt + 1'b1;
  end

  assign o_clkEn      = clkEnQ;
  assign o_halt       = haltQ;
  assign o_bpHit      = bpHitQ;
  assign o_bpHitN     = ~|bpHitQ;
  assign o_cycleCount = cycleCnt;

endmodule
